fetch_ctrl: RTL and testbench

Fetch-stage sequencer that owns the program counter register and turns the per-cycle PC select code from the branch/jump resolution logic into the next fetch address. It arbitrates between X-stage branch/JALR redirects, ID-stage JAL redirects and sequential fetch. It holds the PC under pipeline stall and remembers a redirect that arrives during a stall, and it generates the squash signals for the fetch and decode pipeline registers. It sits between the PC select logic and the instruction memory address port.

---
 rtl/fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch PC sequencer with stall hold, pending redirect and squash.
//            Optional performance counters under PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pc_sel,
    input  logic [31:0]      jal_target,
    input  logic [31:0]      brj_target,
    output logic [31:0]      pc_f,
    output logic             imem_re,
    output logic             kill_f,
    output logic             kill_d,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] brj_cnt,
    input  logic             cnt_clr
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_PEND = 2'd3;

    localparam logic [1:0] c_sel_jal = 2'b01;
    localparam logic [1:0] c_sel_brj = 2'b10;

    logic [1:0]  r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pend_pc, w_pend_pc_nxt;
    logic        r_pend_brj, w_pend_brj_nxt;
    logic        w_brj, w_jal, w_jal_ok, w_accept;
    logic [31:0] w_tgt;
    logic        w_unused;

    assign w_unused = ^{cnt_clr, jal_target[1:0], brj_target[1:0]};

    // A jal is dropped only when an older brj is already waiting.
    assign w_brj    = (r_state != S_BOOT) && (pc_sel == c_sel_brj);
    assign w_jal    = (r_state != S_BOOT) && (pc_sel == c_sel_jal);
    assign w_jal_ok = w_jal && !((r_state == S_PEND) && r_pend_brj);
    assign w_accept = w_brj || w_jal_ok;
    assign w_tgt    = w_brj ? {brj_target[31:2], 2'b00} : {jal_target[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_pend_pc  <= 32'd0;
            r_pend_brj <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_pend_brj <= w_pend_brj_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_pend_brj_nxt = r_pend_brj;
        case (r_state)
            S_BOOT: w_state_nxt = stall ? S_HOLD : S_RUN;
            S_RUN, S_HOLD: begin
                if (stall) begin
                    if (w_accept) begin
                        w_state_nxt    = S_PEND;
                        w_pend_pc_nxt  = w_tgt;
                        w_pend_brj_nxt = w_brj;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = w_accept ? w_tgt : r_pc + 32'd4;
                end
            end
            S_PEND: begin
                if (stall) begin
                    if (w_accept) begin
                        w_pend_pc_nxt  = w_tgt;
                        w_pend_brj_nxt = w_brj;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = w_accept ? w_tgt : r_pend_pc;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        imem_re = (r_state != S_HOLD) && (r_state != S_PEND);
        kill_f  = w_brj || w_jal;
        kill_d  = w_brj;
    end

    assign pc_f = r_pc;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_redirect_cnt, r_brj_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_cnt <= '0;
            r_brj_cnt      <= '0;
        end else if (cnt_clr) begin
            r_redirect_cnt <= '0;
            r_brj_cnt      <= '0;
        end else begin
            if (w_accept && (r_redirect_cnt != '1))
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            if (w_brj && (r_brj_cnt != '1))
                r_brj_cnt <= r_brj_cnt + CNT_W'(1);
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign brj_cnt      = r_brj_cnt;
`else
    assign redirect_cnt = '0;
    assign brj_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl (rule-level model + literals).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam int          CNT_W    = 4;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic [1:0]       pc_sel;
    logic [31:0]      jal_target, brj_target;
    logic [31:0]      pc_f;
    logic             imem_re, kill_f, kill_d;
    logic [CNT_W-1:0] redirect_cnt, brj_cnt;
    logic             cnt_clr;

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel),
        .jal_target(jal_target), .brj_target(brj_target),
        .pc_f(pc_f), .imem_re(imem_re), .kill_f(kill_f), .kill_d(kill_d),
        .redirect_cnt(redirect_cnt), .brj_cnt(brj_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: booting flag, stalled flag, optional pending target.
    int unsigned m_pc, m_pt, m_rc, m_bc, m_t;
    bit          m_boot, m_held, m_pv, m_pb, m_b, m_j;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = RESET_PC; m_boot = 1; m_held = 0; m_pv = 0; m_pb = 0;
            m_rc = 0; m_bc = 0;
        end else begin
            m_b = !m_boot && (pc_sel == 2'b10);
            m_j = !m_boot && (pc_sel == 2'b01) && !(m_pv && m_pb);
            m_t = m_b ? (brj_target & ~32'd3) : (jal_target & ~32'd3);
            if (m_boot) begin
                m_boot = 0;
                m_held = stall;
            end else if (stall) begin
                m_held = 1;
                if (m_b || m_j) begin m_pv = 1; m_pt = m_t; m_pb = m_b; end
            end else begin
                if (m_b || m_j)  m_pc = m_t;
                else if (m_pv)   m_pc = m_pt;
                else             m_pc = m_pc + 32'd4;
                m_pv = 0;
                m_held = 0;
            end
            if (cnt_clr) begin
                m_rc = 0; m_bc = 0;
            end else begin
                if ((m_b || m_j) && m_rc < CNT_MAX) m_rc++;
                if (m_b && m_bc < CNT_MAX) m_bc++;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_pc_f", pc_f, m_pc);
        chk("cyc_imem_re", {31'd0, imem_re}, {31'd0, !m_held});
        chk("cyc_kill_f", {31'd0, kill_f}, {31'd0, !m_boot && (pc_sel == 2'b01 || pc_sel == 2'b10)});
        chk("cyc_kill_d", {31'd0, kill_d}, {31'd0, !m_boot && (pc_sel == 2'b10)});
`ifdef PERF_CNT_EN
        chk("cyc_redirect_cnt", {28'd0, redirect_cnt}, m_rc);
        chk("cyc_brj_cnt", {28'd0, brj_cnt}, m_bc);
`else
        chk("cyc_redirect_cnt", {28'd0, redirect_cnt}, 32'd0);
        chk("cyc_brj_cnt", {28'd0, brj_cnt}, 32'd0);
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; pc_sel = 2'b10; cnt_clr = 0;
        jal_target = 32'h0; brj_target = 32'h1234;
        repeat (2) cyc();
        #1;
        chk("rst_pc_f", pc_f, 32'h4000_0000);
        chk("rst_imem_re", {31'd0, imem_re}, 32'd1);
        chk("rst_kill_f", {31'd0, kill_f}, 32'd0);
        chk("rst_kill_d", {31'd0, kill_d}, 32'd0);
        chk("rst_redirect_cnt", {28'd0, redirect_cnt}, 32'd0);

        // Boot cycle ignores the brj on pc_sel, then sequential fetch.
        rst = 0;
        #1 chk("boot_pc_f", pc_f, 32'h4000_0000);
        chk("boot_kill_f", {31'd0, kill_f}, 32'd0);
        cyc(); pc_sel = 2'b00;
        #1 chk("seq0_pc_f", pc_f, 32'h4000_0000);
        cyc(); chk("seq1_pc_f", pc_f, 32'h4000_0004);
        cyc(); chk("seq2_pc_f", pc_f, 32'h4000_0008);
        cyc(); cyc();
        chk("seq4_pc_f", pc_f, 32'h4000_0010);

        pc_sel = 2'b10; brj_target = 32'h4000_0103;
        #1 chk("brj_kill_f", {31'd0, kill_f}, 32'd1);
        chk("brj_kill_d", {31'd0, kill_d}, 32'd1);
        cyc(); pc_sel = 2'b00;
        chk("brj_pc_f", pc_f, 32'h4000_0100);

        // Redirects during a stall: brj overrides the earlier jal.
        stall = 1;
        cyc();
        chk("hold_imem_re", {31'd0, imem_re}, 32'd0);
        pc_sel = 2'b01; jal_target = 32'h200;
        #1 chk("jal_kill_f", {31'd0, kill_f}, 32'd1);
        chk("jal_kill_d", {31'd0, kill_d}, 32'd0);
        cyc(); pc_sel = 2'b10; brj_target = 32'h300;
        cyc(); pc_sel = 2'b00;
        chk("pend_pc_f", pc_f, 32'h4000_0100);
        chk("pend_imem_re", {31'd0, imem_re}, 32'd0);
        pc_sel = 2'b01; jal_target = 32'h500;
        cyc(); pc_sel = 2'b00;
        stall = 0;
        cyc();
        chk("release_pc_f", pc_f, 32'h300);
        cyc();
        chk("release_seq_pc_f", pc_f, 32'h304);

        // Reset while a redirect is pending discards it.
        stall = 1; pc_sel = 2'b10; brj_target = 32'h300;
        cyc(); pc_sel = 2'b00;
        rst = 1;
        #1 chk("rst_pend_pc_f", pc_f, 32'h4000_0000);
        chk("rst_pend_imem_re", {31'd0, imem_re}, 32'd1);
        cyc();
        rst = 0; stall = 0;
        cyc(); chk("rst_pend_seq0", pc_f, 32'h4000_0000);
        cyc(); chk("rst_pend_seq1", pc_f, 32'h4000_0004);

        // Wrap of pc_f + 4, with target low bits masked.
        pc_sel = 2'b10; brj_target = 32'hFFFF_FFF9;
        cyc(); pc_sel = 2'b00;
        chk("wrap0_pc_f", pc_f, 32'hFFFF_FFF8);
        cyc(); chk("wrap1_pc_f", pc_f, 32'hFFFF_FFFC);
        cyc(); chk("wrap2_pc_f", pc_f, 32'h0000_0000);

`ifdef PERF_CNT_EN
        cnt_clr = 1;
        cyc(); cnt_clr = 0;
        chk("clr0_redirect_cnt", {28'd0, redirect_cnt}, 32'd0);
        chk("clr0_brj_cnt", {28'd0, brj_cnt}, 32'd0);
        pc_sel = 2'b01; jal_target = 32'h1000;
        repeat (3) cyc();
        pc_sel = 2'b10; brj_target = 32'h2000;
        repeat (2) cyc();
        pc_sel = 2'b00;
        #1 chk("perf_redirect_cnt", {28'd0, redirect_cnt}, 32'd5);
        chk("perf_brj_cnt", {28'd0, brj_cnt}, 32'd2);
        pc_sel = 2'b10; cnt_clr = 1;
        cyc(); cnt_clr = 0; pc_sel = 2'b00;
        chk("clr1_redirect_cnt", {28'd0, redirect_cnt}, 32'd0);
        chk("clr1_brj_cnt", {28'd0, brj_cnt}, 32'd0);
        pc_sel = 2'b10;
        repeat (17) cyc();
        pc_sel = 2'b00;
        chk("sat_redirect_cnt", {28'd0, redirect_cnt}, 32'd15);
        chk("sat_brj_cnt", {28'd0, brj_cnt}, 32'd15);
`endif

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
